// File: rtl/slave_buffer.sv
// -----------------------------------------------------------------------------
// slave_buffer
//   First-word-fall-through buffer between an upstream beat source and a
//   downstream consumer. Each entry stores {address tag, data}. The buffer also
//   tracks the upstream address sequence: consecutive pushes must carry
//   consecutive addresses (modulo 256). A mismatch raises a sticky error flag.
//   It also counts accepted beats, saturating at 16'hFFFF.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-low reset
//   valid      in   upstream beat valid
//   sdata_in   in   upstream beat data  [WIDTH]
//   addr_in    in   upstream beat address tag [8]
//   ready      out  upstream may transfer this cycle
//   out_valid  out  head entry available downstream
//   out_ready  in   downstream accepts head entry
//   out_data   out  head entry data [WIDTH]
//   out_addr   out  head entry address tag [8]
//   count      out  occupancy 0..DEPTH [$clog2(DEPTH)+1]
//   seq_err    out  sticky address-sequence error
//   beat_cnt   out  accepted-beat counter (saturating) [16]
// -----------------------------------------------------------------------------
module slave_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [WIDTH-1:0]         sdata_in,
  input  logic [7:0]               addr_in,
  output logic                     ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [7:0]               out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     seq_err,
  output logic [15:0]              beat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 8;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  // Storage: address tag in the upper byte, data below it.
  logic [EW-1:0] r_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_first_seen;
  logic [7:0]    r_expected;
  logic          r_seq_err;
  logic [15:0]   r_beat_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_ready;
  logic          w_out_valid;
  logic [EW-1:0] w_head;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic          w_seq_err_nxt;
  logic [15:0]   w_beat_cnt_nxt;

  // Handshake qualifiers and the fall-through head entry.
  // ready looks only at occupancy, so a pop while full does not open the
  // buffer until the following cycle.
  always_comb begin
    w_ready     = rst && (r_count < CNT_FULL);
    w_out_valid = rst && (r_count != CNT_ZERO);
    w_push      = valid && w_ready;
    w_pop       = w_out_valid && out_ready;
    w_head      = r_mem[r_rd_ptr];
  end

  // Next-state for occupancy, pointers, sequence check and beat counter.
  always_comb begin
    w_count_nxt    = r_count;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_seq_err_nxt  = r_seq_err;
    w_beat_cnt_nxt = r_beat_cnt;

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase

    // Pointers are AW bits wide, so they wrap from DEPTH-1 to 0 naturally.
    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end

    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end

    // The very first push after reset has nothing to compare against.
    if (w_push && r_first_seen && (addr_in != r_expected)) begin
      w_seq_err_nxt = 1'b1;
    end else begin
      w_seq_err_nxt = r_seq_err;
    end

    if (w_push && (r_beat_cnt != 16'hFFFF)) begin
      w_beat_cnt_nxt = r_beat_cnt + 16'd1;
    end else begin
      w_beat_cnt_nxt = r_beat_cnt;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count      <= CNT_ZERO;
      r_wr_ptr     <= PTR_ZERO;
      r_rd_ptr     <= PTR_ZERO;
      r_first_seen <= 1'b0;
      r_expected   <= 8'h00;
      r_seq_err    <= 1'b0;
      r_beat_cnt   <= 16'h0000;
    end else begin
      r_count    <= w_count_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_seq_err  <= w_seq_err_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      if (w_push) begin
        r_first_seen <= 1'b1;
        r_expected   <= addr_in + 8'd1;
      end else begin
        r_first_seen <= r_first_seen;
        r_expected   <= r_expected;
      end
    end
  end

  // Entry storage; contents are not cleared by reset (pointers are).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {addr_in, sdata_in};
    end
  end

  assign ready     = w_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_head[WIDTH-1:0];
  assign out_addr  = w_head[EW-1:WIDTH];
  assign count     = r_count;
  assign seq_err   = r_seq_err;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_slave_buffer.sv
module tb_slave_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  sdata_in;
  logic [7:0]  addr_in;
  logic        ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_addr;
  logic [3:0]  count;
  logic        seq_err;
  logic [15:0] beat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  slave_buffer #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .sdata_in  (sdata_in),
    .addr_in   (addr_in),
    .ready     (ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .count     (count),
    .seq_err   (seq_err),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; sdata_in = 8'h00; addr_in = 8'h00; out_ready = 1'b0;

    // Reset
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // Fill: 8 beats, addr 0..7, no draining
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; addr_in = 8'(i); sdata_in = 8'(8'hA0 + i);
      tick();
      if (i == 0) chk("first_visible", 32'(out_valid), 32'd1);
    end
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_ready", 32'(ready), 32'd0);
    chk("fill_seq_err", 32'(seq_err), 32'd0);
    // Beat 9 is held off
    valid = 1'b1; addr_in = 8'h08; sdata_in = 8'hEE;
    tick();
    chk("b9_count", 32'(count), 32'd8);
    chk("b9_beat_cnt", 32'(beat_cnt), 32'd8);
    chk("hold_addr", 32'(out_addr), 32'd0);
    chk("hold_data", 32'(out_data), 32'hA0);
    valid = 1'b0;

    // Drain in order
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_addr", 32'(out_addr), 32'(i));
      chk("drain_data", 32'(out_data), 32'(8'hA0 + i));
      tick();
    end
    chk("drain_empty_valid", 32'(out_valid), 32'd0);
    chk("drain_empty_count", 32'(count), 32'd0);
    // Empty: out_ready ignored
    tick();
    chk("empty_pop_count", 32'(count), 32'd0);

    // Full + pop: refill with addr 8..15
    out_ready = 1'b0;
    for (int i = 8; i < 16; i++) begin
      valid = 1'b1; addr_in = 8'(i); sdata_in = 8'(i);
      tick();
    end
    chk("fp_count", 32'(count), 32'd8);
    valid = 1'b1; addr_in = 8'h10; sdata_in = 8'h10; out_ready = 1'b1;
    #1;
    chk("fp_ready_low", 32'(ready), 32'd0);
    tick();
    valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("fp_count7", 32'(count), 32'd7);
    chk("fp_ready_next", 32'(ready), 32'd1);
    chk("fp_beat_cnt", 32'(beat_cnt), 32'd16);
    chk("fp_head", 32'(out_addr), 32'd9);
    chk("fp_seq_err", 32'(seq_err), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("fp_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset mid-operation with 5 entries
    for (int i = 16; i < 21; i++) begin
      valid = 1'b1; addr_in = 8'(i); sdata_in = 8'(i);
      tick();
    end
    valid = 1'b0;
    chk("mid_count5", 32'(count), 32'd5);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_seq_err", 32'(seq_err), 32'd0);
    chk("mid_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("mid_ready", 32'(ready), 32'd1);

    // Streaming 300 beats, address wrapping through 8'hFF -> 8'h00
    valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      addr_in = 8'(8'hF0 + i); sdata_in = 8'(i) ^ 8'h5A;
      tick();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_addr", 32'(out_addr), 32'(8'(8'hF0 + i)));
      chk("stream_data", 32'(out_data), 32'(8'(i) ^ 8'h5A));
    end
    valid = 1'b0;
    tick();
    chk("stream_end_count", 32'(count), 32'd0);
    chk("stream_seq_err", 32'(seq_err), 32'd0);
    chk("stream_beat_cnt", 32'(beat_cnt), 32'd300);

    // Sequence error: 5, 6, 8, then correct 9, 10
    rst = 1'b0;
    tick();
    rst = 1'b1;
    valid = 1'b1; out_ready = 1'b1;
    addr_in = 8'd5; tick();
    chk("seq_after5", 32'(seq_err), 32'd0);
    addr_in = 8'd6; tick();
    chk("seq_after6", 32'(seq_err), 32'd0);
    addr_in = 8'd8; tick();
    chk("seq_after8", 32'(seq_err), 32'd1);
    addr_in = 8'd9; tick();
    chk("seq_sticky9", 32'(seq_err), 32'd1);
    addr_in = 8'd10; tick();
    chk("seq_sticky10", 32'(seq_err), 32'd1);
    chk("seq_beat_cnt", 32'(beat_cnt), 32'd5);
    valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slave_buffer.md
SLAVE_BUFFER -- requirements
Module: slave_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each beat.
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port valid  input  1  upstream beat valid.
REQ-006 SHALL have port sdata_in  input  WIDTH  upstream beat data.
REQ-007 SHALL have port addr_in  input  8  upstream beat address tag.
REQ-008 SHALL have port ready  output  1  upstream may transfer this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry available downstream.
REQ-010 SHALL have port out_ready  input  1  downstream accepts head entry.
REQ-011 SHALL have port out_data  output  WIDTH  head entry data.
REQ-012 SHALL have port out_addr  output  8  head entry address tag.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port seq_err  output  1  sticky address-sequence error flag.
REQ-015 SHALL have port beat_cnt  output  16  accepted-beat counter.

Function
REQ-016 SHALL accept a beat (push) in a cycle iff valid && ready; pushed entry = {addr_in, sdata_in}.
REQ-017 SHALL drive ready = 1 iff rst is high and count < DEPTH; ready SHALL NOT depend on valid or out_ready.
REQ-018 SHALL operate first-word-fall-through: out_valid = (count != 0); out_data/out_addr = head entry combinationally, no added latency.
REQ-019 SHALL pop the head entry in a cycle iff out_valid && out_ready.
REQ-020 SHALL update count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-021 SHALL, when full (count == DEPTH), hold ready low even if a pop occurs that cycle; ready rises the cycle after the pop.
REQ-022 SHALL, when empty, ignore out_ready; a beat pushed in cycle N becomes visible on out_valid in cycle N+1.
REQ-023 SHALL, when neither full nor empty, allow push and pop in the same cycle without data loss or reordering.
REQ-024 SHALL implement read/write pointers modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-025 SHALL hold out_data/out_addr stable while out_valid && !out_ready.
REQ-026 SHALL hold an internal flag first_seen (0 after reset) and an 8-bit expected address.
REQ-027 SHALL, on each push, load expected = addr_in + 1 modulo 256 (8'hFF -> 8'h00) and set first_seen.
REQ-028 SHALL, on a push with first_seen = 1 and addr_in != expected, set seq_err; seq_err remains 1 until reset.
REQ-029 SHALL treat the first push after reset as sequence-correct for any addr_in.
REQ-030 SHALL increment beat_cnt by 1 on each push, saturating at 16'hFFFF.

Reset
REQ-031 SHALL, while rst = 0 at a rising edge, clear count, pointers, first_seen, expected, seq_err and beat_cnt to 0.
REQ-032 SHALL drive ready = 0 and out_valid = 0 while rst = 0; buffer contents need not be cleared.
REQ-033 SHALL, on reset mid-operation, discard all buffered entries; out_valid = 0 the cycle after reset is sampled.
REQ-034 SHALL assert ready = 1 in the first cycle with rst = 1 following reset.

Verification
REQ-035 SHALL verify fill: out_ready = 0, push DEPTH beats addr 0..7 -> count = 8, ready = 0, beat 9 held off, seq_err = 0.
REQ-036 SHALL verify drain order: after fill, out_ready = 1 -> out_addr 0..7 in order, one per cycle, then out_valid = 0.
REQ-037 SHALL verify streaming: valid = out_ready = 1 continuously for 300 beats, addr wrapping 8'hFF -> 8'h00 -> count stays 1, seq_err = 0, beat_cnt = 300.
REQ-038 SHALL verify sequence error: push addr 5, 6, 8 -> seq_err = 1 after third push and stays 1 through subsequent correct beats.
REQ-039 SHALL verify full + pop: count = 8, pop with valid = 1 -> no push that cycle, count = 7, ready = 1 next cycle.
REQ-040 SHALL verify reset mid-operation: count = 5, rst = 0 one cycle -> count = 0, out_valid = 0, seq_err = 0, beat_cnt = 0, ready = 1 after release.
